// File: rtl/switch_step_debouncer.sv
// rtl/switch_step_debouncer.sv - two-flop synchronizer, counter debouncer, press/release pulses
// and a step pulse stream with hold-to-auto-repeat.
module switch_step_debouncer #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  input  logic i_Repeat_En,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Step
);

  localparam int CW   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] T_ZERO  = '0;
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } state_t;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] db_cnt;
  logic          accept;
  logic          sw_next;
  state_t        state;
  logic [TW-1:0] timer;

  // accept marks the edge on which o_Switch takes the synced level
  assign accept  = (sync2 != o_Switch) && (db_cnt == DB_LAST);
  assign sw_next = accept ? sync2 : o_Switch;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      o_Switch  <= 1'b0;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
    end else begin
      sync1     <= i_Switch;
      sync2     <= sync1;
      o_Switch  <= sw_next;
      o_Press   <= accept & sync2;
      o_Release <= accept & ~sync2;
      if (sync2 == o_Switch || accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // timer counts edges since the last step; a disabled hold parks it at 1.
  // Expiry steps are gated by sw_next so a coincident release suppresses them.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state  <= IDLE;
      timer  <= '0;
      o_Step <= 1'b0;
    end else begin
      o_Step <= 1'b0;
      case (state)
        IDLE: begin
          timer <= T_ZERO;
          if (accept && sync2) begin
            o_Step <= 1'b1;
            state  <= HOLD_DELAY;
          end
        end
        HOLD_DELAY: begin
          if (!o_Switch) begin
            state <= IDLE;
            timer <= T_ZERO;
          end else if (!i_Repeat_En) begin
            timer <= T_ONE;
          end else if (timer == RD_LAST) begin
            o_Step <= sw_next;
            timer  <= T_ZERO;
            state  <= HOLD_REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD_REPEAT: begin
          if (!o_Switch) begin
            state <= IDLE;
            timer <= T_ZERO;
          end else if (!i_Repeat_En) begin
            timer <= T_ONE;
            state <= HOLD_DELAY;
          end else if (timer == RR_LAST) begin
            o_Step <= sw_next;
            timer  <= T_ZERO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= T_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_step_debouncer.sv
// tb/tb_switch_step_debouncer.sv - directed vector bench for switch_step_debouncer
module tb_switch_step_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  logic en  = 1'b1;
  logic o_sw, o_press, o_rel, o_step;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       sw;
    logic       en;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[80];
  int   nvec = 0;

  switch_step_debouncer #(
    .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY  (10),
    .REPEAT_RATE   (3)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Switch   (sw),
    .i_Repeat_En(en),
    .o_Switch   (o_sw),
    .o_Press    (o_press),
    .o_Release  (o_rel),
    .o_Step     (o_step)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {o_sw, o_press, o_rel, o_step};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got {sw,press,rel,step}=%b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic s, input logic e, input logic [3:0] x);
    vecs[nvec].sw  = s;
    vecs[nvec].en  = e;
    vecs[nvec].exp = x;
    nvec++;
  endtask

  initial begin
    int n_press, n_rel, n_step, n_both;

    // clean press held to edge 17: steps 6,16,19,22, release pulse at 23
    for (int k = 1; k <= 28; k++)
      push(k <= 17, 1'b1, {(k >= 6 && k <= 22), (k == 6), (k == 23),
                           (k == 6 || k == 16 || k == 19 || k == 22)});
    // held to edge 19: release lands on the edge-25 repeat expiry, no step there
    for (int k = 1; k <= 30; k++)
      push(k <= 19, 1'b1, {(k >= 6 && k <= 24), (k == 6), (k == 25),
                           (k == 6 || k == 16 || k == 19 || k == 22)});

    tick();
    tick();
    check("reset_hold", 0, outs(), 4'b0000);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("after_reset", k, outs(), 4'b0000);
    end

    for (int i = 0; i < nvec; i++) begin
      sw = vecs[i].sw;
      en = vecs[i].en;
      tick();
      check("vec", i, outs(), vecs[i].exp);
    end

    // bounce: 3-cycle highs and lows never reach the debounce limit
    for (int k = 1; k <= 34; k++) begin
      sw = (k <= 24) && (((k - 1) % 6) < 3);
      tick();
      check("bounce", k, outs(), 4'b0000);
    end

    // repeat disabled until edge 30, then steps at 39, 42, 45, 48
    for (int k = 1; k <= 50; k++) begin
      sw = 1'b1;
      en = (k >= 31);
      tick();
      check("no_repeat_step", k, {3'b000, o_step},
            {3'b000, (k == 6 || k == 39 || k == 42 || k == 45 || k == 48)});
    end
    sw = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("no_repeat_idle", 0, outs(), 4'b0000);

    // reset mid-hold at edge 12, released after edge 14
    for (int k = 1; k <= 12; k++) begin
      sw = 1'b1;
      tick();
    end
    check("pre_reset", 12, outs(), 4'b1000);
    rst = 1'b1;
    #1;
    check("async_reset", 12, outs(), 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 15; k <= 22; k++) begin
      tick();
      check("post_reset", k, outs(), (k == 20) ? 4'b1101 : ((k > 20) ? 4'b1000 : 4'b0000));
    end
    sw = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    // twelve separated presses
    n_press = 0;
    n_rel   = 0;
    n_step  = 0;
    n_both  = 0;
    for (int p = 0; p < 12; p++) begin
      for (int k = 0; k < 18; k++) begin
        sw = (k < 8);
        tick();
        n_press += int'(o_press);
        n_rel   += int'(o_rel);
        n_step  += int'(o_step);
        n_both  += int'(o_press & o_rel);
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_rel += int'(o_rel);
    end
    check_int("press_count", n_press, 12);
    check_int("release_count", n_rel, 12);
    check_int("step_count", n_step, 12);
    check_int("press_release_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
